// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Op codes follow the RV32M funct3 ordering.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return o[2];
    endfunction

    function automatic logic op_is_rem(input mdu_op_e o);
        return (o == MDU_REM) || (o == MDU_REMU);
    endfunction

    function automatic logic rs1_signed(input mdu_op_e o);
        return o inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic rs2_signed(input mdu_op_e o);
        return o inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift the remainder/dividend pair left,
// trial-subtract the divisor and keep the difference when it did not borrow.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            q_o
);

    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    // Trial subtraction; the quotient bit enters the vacated dividend LSB.
    always_comb begin
        shl   = {rem_i, dvd_i[XLEN-1]};
        diff  = shl - {1'b0, dvs_i};
        q_o   = ~diff[XLEN];
        rem_o = q_o ? diff[XLEN-1:0] : shl[XLEN-1:0];
        dvd_o = {dvd_i[XLEN-2:0], q_o};
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Works on operand magnitudes; the sign is restored in the last CALC cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mdu_op_e           op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_valid_q, busy_q;

    mdu_op_e           op_in;
    logic              a_neg, b_neg, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div0, ovf, special, accept;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   rem_nxt, dvd_nxt;
    logic              q_bit;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;

    // Turns an unsigned magnitude result into the rd value for the op.
    function automatic logic [XLEN-1:0] finish(
        input mdu_op_e         o,
        input logic            n,
        input logic [2*XLEN-1:0] a
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = n ? -a : a;
        q = n ? -a[XLEN-1:0] : a[XLEN-1:0];
        r = n ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        case (o)
            MDU_MUL:                          return p[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  return p[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                return q;
            default:                          return r;
        endcase
    endfunction

    div_restoring_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (acc_q[2*XLEN-1:XLEN]),
        .dvd_i (acc_q[XLEN-1:0]),
        .dvs_i (b_q),
        .rem_o (rem_nxt),
        .dvd_o (dvd_nxt),
        .q_o   (q_bit)
    );

    // Operand decode, special-case detection and the shift-add step.
    always_comb begin
        op_in   = mdu_op_e'(op);
        a_neg   = rs1_signed(op_in) & r1[XLEN-1];
        b_neg   = rs2_signed(op_in) & r2[XLEN-1];
        a_mag   = a_neg ? -r1 : r1;
        b_mag   = b_neg ? -r2 : r2;
        res_neg = op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
        div0    = op_is_div(op_in) && (r2 == '0);
        ovf     = op_is_div(op_in) && !op_in[0] && (r1 == SMIN) && (r2 == '1);
        special = div0 || ovf || (FAST_MUL && !op_is_div(op_in));
        accept  = in_valid && in_ready && !flush;
        prod    = FAST_MUL ? (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag) : '0;
        if (div0) begin
            special_res = op_is_rem(op_in) ? r1 : '1;
        end else if (ovf) begin
            special_res = op_is_rem(op_in) ? '0 : SMIN;
        end else begin
            special_res = finish(op_in, res_neg, prod);
        end
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides accept and the output handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == CW'(XLEN)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // FSM outputs decoded from state alone.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath next values: load on accept, step in CALC, finish at the end.
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        acc_d      = acc_q;
        b_d        = b_q;
        out_data_d = out_data_q;
        out_rd_d   = out_rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d    = '0;
                    op_d     = op_in;
                    neg_d    = res_neg;
                    acc_d    = {{XLEN{1'b0}}, a_mag};
                    b_d      = b_mag;
                    out_rd_d = rd;
                    if (special) out_data_d = special_res;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q < CW'(XLEN)) begin
                    acc_d = op_is_div(op_q) ? {rem_nxt, dvd_nxt} : mul_nxt;
                end else begin
                    out_data_d = finish(op_q, neg_q, acc_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_q        <= MDU_MUL;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: iterative instance plus a FAST_MUL one.
// Expected results come from 64-bit arithmetic on the RV32M rules.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] r1, r2, out_data;
    logic [4:0]  rd, out_rd;

    logic        f_in_valid, f_in_ready, f_flush, f_out_valid, f_out_ready, f_busy;
    logic [2:0]  f_op;
    logic [31:0] f_r1, f_r2, f_out_data;
    logic [4:0]  f_rd, f_out_rd;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;
    logic        pv = 1'b0;
    logic [31:0] pd = '0;

    ex_muldiv #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .r1(r1), .r2(r2), .rd(rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .busy(busy)
    );

    ex_muldiv #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .op(f_op), .r1(f_r1), .r2(f_r2), .rd(f_rd), .flush(f_flush),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
        .out_rd(f_out_rd), .busy(f_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the start of the accepting cycle to out_valid, FAST_MUL=0.
    function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: latency at the rising edge of out_valid, data on handshake.
    always @(negedge clk) begin
        if (out_valid && !pv) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: out_valid with nothing outstanding, data %h", out_data);
            end else begin
                chk("latency", 32'(cyc), 32'(sbq[0].due));
            end
        end
        if (out_valid && pv) chk("hold_stable", out_data, pd);
        if (out_valid && out_ready && sbq.size() > 0) begin
            chk("data", out_data, sbq[0].d);
            chk("rd", 32'(out_rd), 32'(sbq[0].rd));
            void'(sbq.pop_front());
        end
        pv <= out_valid;
        pd <= out_data;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ready: in_ready never returned");
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit track,
                         input logic [31:0] expv, input int l);
        exp_t e;
        wait_idle();
        in_valid = 1'b1;
        op = o;
        r1 = a;
        r2 = b;
        rd = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (track) begin
            e.d   = expv;
            e.rd  = r;
            e.due = cyc + l - 1;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic fast_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expv);
        @(negedge clk);
        f_in_valid = 1'b1;
        f_op = o;
        f_r1 = a;
        f_r2 = b;
        f_rd = 5'd7;
        @(posedge clk);
        #1;
        f_in_valid = 1'b0;
        @(negedge clk);
        chk("fast_valid", 32'(f_out_valid), 32'd1);
        chk("fast_data", f_out_data, expv);
        @(negedge clk);
        chk("fast_idle", 32'(f_in_ready), 32'd1);
    endtask

    initial begin
        int          n;
        logic [2:0]  o;
        logic [31:0] a, b;
        in_valid = 0; op = 0; r1 = 0; r2 = 0; rd = 0; flush = 0; out_ready = 1;
        f_in_valid = 0; f_op = 0; f_r1 = 0; f_r2 = 0; f_rd = 0; f_flush = 0; f_out_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        fast_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        fast_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        fast_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        fast_op(3'd0, 32'd6, 32'd7, 32'd42);

        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 1, 32'hFFFF_FFFD, 34);
        chk("busy_calc", 32'(busy), 32'd1);
        chk("ready_calc", 32'(in_ready), 32'd0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 1, 32'hFFFF_FFFF, 34);
        issue(3'd5, 32'h8000_0000, 32'd0, 5'd3, 1, 32'hFFFF_FFFF, 1);
        issue(3'd6, 32'd5, 32'd0, 5'd4, 1, 32'd5, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1, 32'h8000_0000, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 32'd0, 1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1, 32'd0, 34);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1, 32'hFFFF_FFFE, 34);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1, 32'hFFFF_FFFF, 34);
        issue(3'd7, 32'd100, 32'd7, 5'd10, 1, 32'd2, 34);
        drain();

        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd12, 1, 32'd14, 34);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", 32'(in_ready), 32'd1);
        drain();

        issue(3'd4, 32'd1000, 32'd3, 5'd13, 0, 32'd0, 0);
        repeat (12) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        repeat (40) @(negedge clk);

        wait_idle();
        in_valid = 1'b1;
        flush = 1'b1;
        op = 3'd0;
        r1 = 32'd3;
        r2 = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_accept_busy", 32'(busy), 32'd0);
        chk("flush_accept_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);

        issue(3'd0, 32'd3, 32'd5, 5'd9, 1, 32'd15, 34);
        drain();
        issue(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd10, 0, 32'd0, 0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        #2 rst_n = 1'b1;
        issue(3'd0, 32'd6, 32'd7, 5'd11, 1, 32'd42, 34);
        drain();

        rand_ready = 1'b1;
        repeat (150) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(o, a, b, 5'($urandom_range(1, 31)), 1, model(o, a, b), lat(o, a, b));
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
